// File: rtl/id_stage_if.sv
// Bundle of decode-stage data and control signals between id_stage and its neighbours.
// master drives fetch/write-back inputs; slave is the decode stage itself.
interface id_stage_if;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] wdi;
    logic        rsrtequ;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [1:0]  pcsource;
    logic        m2reg;
    logic        wmem;
    logic [2:0]  aluc;
    logic        aluimm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        shift;

    modport master (
        output pc4, inst, wdi, rsrtequ,
        input  bpc, jpc, pcsource, m2reg, wmem, aluc, aluimm, a, b, imm, shift
    );

    modport slave (
        input  pc4, inst, wdi, rsrtequ,
        output bpc, jpc, pcsource, m2reg, wmem, aluc, aluimm, a, b, imm, shift
    );
endinterface

// File: rtl/id_stage.sv
// mips_v5 instruction decode: 32x32 register file, main control unit, branch/jump targets.
// Optional ID_STAGE_REG_BYPASS_EN forwards same-cycle write data onto the a/b read ports.
module id_stage (
    input  logic       clk,
    input  logic       clrn,
    id_stage_if.slave  bus
);
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    logic [25:0] addr;

    assign op    = bus.inst[31:26];
    assign rs    = bus.inst[25:21];
    assign rt    = bus.inst[20:16];
    assign rd    = bus.inst[15:11];
    assign sa    = bus.inst[10:6];
    assign func  = bus.inst[5:0];
    assign imm16 = bus.inst[15:0];
    assign addr  = bus.inst[25:0];

    logic       wreg, regrt, jal, sext, lui;
    logic [1:0] pcsource;
    logic [2:0] aluc;
    logic       m2reg, wmem, aluimm, shift;

    always_comb begin
        wreg     = 1'b0;
        regrt    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b1;
        lui      = 1'b0;
        pcsource = 2'b00;
        aluc     = 3'b000;
        m2reg    = 1'b0;
        wmem     = 1'b0;
        aluimm   = 1'b0;
        shift    = 1'b0;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000: begin wreg = 1'b1; aluc = 3'b000; end
                    6'b100010: begin wreg = 1'b1; aluc = 3'b001; end
                    6'b100100: begin wreg = 1'b1; aluc = 3'b010; end
                    6'b100101: begin wreg = 1'b1; aluc = 3'b011; end
                    6'b100110: begin wreg = 1'b1; aluc = 3'b100; end
                    6'b000000: begin wreg = 1'b1; shift = 1'b1; aluc = 3'b101; end
                    6'b000010: begin wreg = 1'b1; shift = 1'b1; aluc = 3'b110; end
                    6'b000011: begin wreg = 1'b1; shift = 1'b1; aluc = 3'b111; end
                    6'b001000: pcsource = 2'b10;
                    default: ;
                endcase
            end
            6'b001000: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; end
            6'b001100: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b0; aluc = 3'b010; end
            6'b001101: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b0; aluc = 3'b011; end
            6'b001110: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b0; aluc = 3'b100; end
            6'b100011: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; m2reg = 1'b1; end
            6'b101011: begin aluimm = 1'b1; wmem = 1'b1; end
            6'b000100: begin aluc = 3'b001; pcsource = bus.rsrtequ ? 2'b01 : 2'b00; end
            6'b000101: begin aluc = 3'b001; pcsource = bus.rsrtequ ? 2'b00 : 2'b01; end
            // lui adds the shifted immediate to rs, which the assembler sets to r0
            6'b001111: begin wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; lui = 1'b1; end
            6'b000010: pcsource = 2'b11;
            6'b000011: begin pcsource = 2'b11; wreg = 1'b1; jal = 1'b1; end
            default: ;
        endcase
    end

    logic [4:0]  wn;
    logic [31:0] wd;
    logic        we;
    logic [31:0] regs [32];

    assign wn = jal ? 5'd31 : (regrt ? rt : rd);
    assign wd = jal ? bus.pc4 : bus.wdi;
    assign we = wreg && (wn != 5'd0) && !clrn;

    // r0 is cleared by reset and never written, so it reads as zero
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (we) begin
            regs[wn] <= wd;
        end
    end

    logic [31:0] qa, qb;

`ifdef ID_STAGE_REG_BYPASS_EN
    assign qa = (rs == 5'd0) ? 32'h0 : ((we && wn == rs) ? wd : regs[rs]);
    assign qb = (rt == 5'd0) ? 32'h0 : ((we && wn == rt) ? wd : regs[rt]);
`else
    assign qa = (rs == 5'd0) ? 32'h0 : regs[rs];
    assign qb = (rt == 5'd0) ? 32'h0 : regs[rt];
`endif

    logic [31:0] sx_imm;
    assign sx_imm = {{16{imm16[15]}}, imm16};

    assign bus.a        = shift ? {27'b0, sa} : qa;
    assign bus.b        = qb;
    assign bus.imm      = lui ? {imm16, 16'h0} : (sext ? sx_imm : {16'h0, imm16});
    assign bus.bpc      = bus.pc4 + {sx_imm[29:0], 2'b00};
    assign bus.jpc      = {bus.pc4[31:28], addr, 2'b00};
    assign bus.pcsource = pcsource;
    assign bus.aluc     = aluc;
    assign bus.m2reg    = m2reg;
    assign bus.wmem     = wmem;
    assign bus.aluimm   = aluimm;
    assign bus.shift    = shift;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized instructions
// checked against a mnemonic-level reference model of decode and the register file.
module tb_id_stage;
    logic clk = 1'b0;
    logic clrn;
    id_stage_if bus ();

    id_stage dut (.clk(clk), .clrn(clrn), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_JR,
                  M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE,
                  M_LUI, M_J, M_JAL, M_BAD} mn_t;

    logic [31:0] ref_regs [32];
    logic [31:0] e_bpc, e_jpc, e_a, e_b, e_imm, e_wd;
    logic [1:0]  e_pcs;
    logic [2:0]  e_aluc;
    logic        e_m2, e_wm, e_ai, e_sh, e_we;
    logic [4:0]  e_wn;

    function automatic mn_t classify(input logic [31:0] i);
        mn_t m;
        m = M_BAD;
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h20: m = M_ADD;  6'h22: m = M_SUB;  6'h24: m = M_AND;
                6'h25: m = M_OR;   6'h26: m = M_XOR;  6'h00: m = M_SLL;
                6'h02: m = M_SRL;  6'h03: m = M_SRA;  6'h08: m = M_JR;
                default: m = M_BAD;
            endcase
        end else begin
            case (i[31:26])
                6'h08: m = M_ADDI; 6'h0C: m = M_ANDI; 6'h0D: m = M_ORI;
                6'h0E: m = M_XORI; 6'h23: m = M_LW;   6'h2B: m = M_SW;
                6'h04: m = M_BEQ;  6'h05: m = M_BNE;  6'h0F: m = M_LUI;
                6'h02: m = M_J;    6'h03: m = M_JAL;
                default: m = M_BAD;
            endcase
        end
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef ID_STAGE_REG_BYPASS_EN
        if (e_we && !clrn && e_wn == r) return e_wd;
`endif
        return ref_regs[r];
    endfunction

    task automatic predict();
        mn_t m;
        logic [31:0] i;
        logic signed [15:0] s16;
        i   = bus.inst;
        m   = classify(i);
        s16 = i[15:0];
        case (m)
            M_SUB, M_BEQ, M_BNE: e_aluc = 3'd1;
            M_AND, M_ANDI:       e_aluc = 3'd2;
            M_OR, M_ORI:         e_aluc = 3'd3;
            M_XOR, M_XORI:       e_aluc = 3'd4;
            M_SLL:               e_aluc = 3'd5;
            M_SRL:               e_aluc = 3'd6;
            M_SRA:               e_aluc = 3'd7;
            default:             e_aluc = 3'd0;
        endcase
        case (m)
            M_BEQ:      e_pcs = bus.rsrtequ ? 2'd1 : 2'd0;
            M_BNE:      e_pcs = bus.rsrtequ ? 2'd0 : 2'd1;
            M_JR:       e_pcs = 2'd2;
            M_J, M_JAL: e_pcs = 2'd3;
            default:    e_pcs = 2'd0;
        endcase
        e_ai = m inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_LUI};
        e_sh = m inside {M_SLL, M_SRL, M_SRA};
        e_m2 = (m == M_LW);
        e_wm = (m == M_SW);
        if (m inside {M_ANDI, M_ORI, M_XORI}) e_imm = {16'h0, i[15:0]};
        else if (m == M_LUI)                  e_imm = {16'h0, i[15:0]} * 32'd65536;
        else                                  e_imm = 32'(s16);
        e_bpc = bus.pc4 + 32'(s16) * 32'd4;
        e_jpc = (bus.pc4 & 32'hF000_0000) | ({6'h0, i[25:0]} * 32'd4);
        e_we  = m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA,
                          M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_LUI, M_JAL};
        if (m == M_JAL) e_wn = 5'd31;
        else if (m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA}) e_wn = i[15:11];
        else e_wn = i[20:16];
        e_wd = (m == M_JAL) ? bus.pc4 : bus.wdi;
        e_a  = e_sh ? {27'h0, i[10:6]} : model_read(i[25:21]);
        e_b  = model_read(i[20:16]);
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        if (!clrn && e_we && e_wn != 5'd0) ref_regs[e_wn] = e_wd;
        #1;
    endtask

    function automatic logic [31:0] rtype(input int s, input int t, input int d, input int sh, input int fn);
        return {6'h0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
    endfunction

    task automatic test_reset();
        bus.inst = 32'h0022_1820;
        bus.pc4 = 32'h0; bus.wdi = 32'h0; bus.rsrtequ = 1'b0;
        clrn = 1'b0;
        #1 clrn = 1'b1;
        for (int r = 0; r < 32; r++) ref_regs[r] = 32'h0;
        #1;
        checks++;
        if (bus.a !== 32'h0 || bus.b !== 32'h0) begin
            errors++; $display("FAIL reset_hold a=%h b=%h expected 0 0", bus.a, bus.b);
        end
        clrn = 1'b0;
        #1;
        checks++;
        if (bus.a !== 32'h0 || bus.b !== 32'h0) begin
            errors++; $display("FAIL reset_release a=%h b=%h expected 0 0", bus.a, bus.b);
        end
    endtask

    task automatic test_write_read();
        bus.inst = 32'h2005_0007; bus.wdi = 32'h1234_5678;
        #1;
        checks++;
        if (bus.imm !== 32'h7 || bus.aluimm !== 1'b1 || bus.aluc !== 3'b000) begin
            errors++; $display("FAIL addi_decode imm=%h aluimm=%b aluc=%b expected 7 1 000", bus.imm, bus.aluimm, bus.aluc);
        end
        checks++;
        if (bus.b !== 32'h0) begin
            errors++; $display("FAIL same_cycle_old b=%h expected 0", bus.b);
        end
        step();
        bus.inst = rtype(5, 0, 0, 0, 6'h20);
        #1;
        checks++;
        if (bus.a !== 32'h1234_5678) begin
            errors++; $display("FAIL write_read a=%h expected 12345678", bus.a);
        end
    endtask

    task automatic test_branch();
        bus.pc4 = 32'h100; bus.inst = 32'h1022_FFFF; bus.rsrtequ = 1'b1;
        #1;
        checks++;
        if (bus.pcsource !== 2'b01 || bus.bpc !== 32'hFC || bus.aluc !== 3'b001) begin
            errors++; $display("FAIL beq_taken pcsource=%b bpc=%h aluc=%b expected 01 fc 001", bus.pcsource, bus.bpc, bus.aluc);
        end
        bus.rsrtequ = 1'b0;
        #1;
        checks++;
        if (bus.pcsource !== 2'b00) begin
            errors++; $display("FAIL beq_not_taken pcsource=%b expected 00", bus.pcsource);
        end
        bus.inst = 32'h1422_FFFF;
        #1;
        checks++;
        if (bus.pcsource !== 2'b01) begin
            errors++; $display("FAIL bne_taken pcsource=%b expected 01", bus.pcsource);
        end
        bus.rsrtequ = 1'b1;
        #1;
        checks++;
        if (bus.pcsource !== 2'b00) begin
            errors++; $display("FAIL bne_not_taken pcsource=%b expected 00", bus.pcsource);
        end
    endtask

    task automatic test_jump();
        bus.pc4 = 32'h1000_0004; bus.inst = 32'h0C00_0040; bus.wdi = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.pcsource !== 2'b11 || bus.jpc !== 32'h1000_0100) begin
            errors++; $display("FAIL jal_decode pcsource=%b jpc=%h expected 11 10000100", bus.pcsource, bus.jpc);
        end
        step();
        bus.inst = rtype(31, 0, 0, 0, 6'h08);
        #1;
        checks++;
        if (bus.a !== 32'h1000_0004 || bus.pcsource !== 2'b10) begin
            errors++; $display("FAIL jal_link_jr a=%h pcsource=%b expected 10000004 10", bus.a, bus.pcsource);
        end
    endtask

    task automatic test_shift_lui_sw();
        bus.inst = 32'h0003_1103;
        #1;
        checks++;
        if (bus.shift !== 1'b1 || bus.a !== 32'h4 || bus.aluc !== 3'b111) begin
            errors++; $display("FAIL sra_decode shift=%b a=%h aluc=%b expected 1 4 111", bus.shift, bus.a, bus.aluc);
        end
        bus.inst = 32'h3C01_ABCD;
        #1;
        checks++;
        if (bus.imm !== 32'hABCD_0000 || bus.aluc !== 3'b000 || bus.aluimm !== 1'b1) begin
            errors++; $display("FAIL lui_decode imm=%h aluc=%b aluimm=%b expected abcd0000 000 1", bus.imm, bus.aluc, bus.aluimm);
        end
        bus.inst = 32'hAC05_0000; bus.wdi = 32'h5555_AAAA;
        #1;
        checks++;
        if (bus.wmem !== 1'b1 || bus.m2reg !== 1'b0) begin
            errors++; $display("FAIL sw_decode wmem=%b m2reg=%b expected 1 0", bus.wmem, bus.m2reg);
        end
        step();
        bus.inst = rtype(0, 5, 0, 0, 6'h20);
        #1;
        checks++;
        if (bus.b !== 32'h1234_5678) begin
            errors++; $display("FAIL sw_no_write b=%h expected 12345678", bus.b);
        end
    endtask

    task automatic test_r0();
        bus.inst = 32'h2000_0005; bus.wdi = 32'h5;
        step();
        bus.inst = rtype(0, 0, 0, 0, 6'h20);
        #1;
        checks++;
        if (bus.a !== 32'h0 || bus.b !== 32'h0) begin
            errors++; $display("FAIL r0_protect a=%h b=%h expected 0 0", bus.a, bus.b);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [11];
        logic [5:0] fns [9];
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        logic [168:0] got, exp;
        ops = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0F, 6'h02, 6'h03};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08};
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) op = 6'($urandom);
            else if ($urandom_range(0, 2) == 0) op = 6'h00;
            else op = ops[$urandom_range(0, 10)];
            fn = ($urandom_range(0, 15) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
            rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            bus.inst    = {op, rs, rt, rd, 5'($urandom), fn};
            bus.pc4     = $urandom;
            bus.wdi     = $urandom;
            bus.rsrtequ = 1'($urandom_range(0, 1));
            #1;
            predict();
            got = {bus.bpc, bus.jpc, bus.pcsource, bus.m2reg, bus.wmem, bus.aluc,
                   bus.aluimm, bus.a, bus.b, bus.imm, bus.shift};
            exp = {e_bpc, e_jpc, e_pcs, e_m2, e_wm, e_aluc, e_ai, e_a, e_b, e_imm, e_sh};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d] inst=%h got=%h expected=%h", n, bus.inst, got, exp);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        #2 clrn = 1'b1;
        for (int r = 0; r < 32; r++) ref_regs[r] = 32'h0;
        for (int i = 1; i < 32; i += 2) begin
            bus.inst = rtype(i, (i + 1) % 32, i, 0, 6'h20);
            bus.wdi  = $urandom | 32'h1;
            #1;
            checks++;
            if (bus.a !== 32'h0 || bus.b !== 32'h0) begin
                errors++; $display("FAIL mid_reset r%0d a=%h b=%h expected 0 0", i, bus.a, bus.b);
            end
            step();
        end
        clrn = 1'b0;
        bus.inst = rtype(1, 3, 0, 0, 6'h20);
        #1;
        checks++;
        if (bus.a !== 32'h0 || bus.b !== 32'h0) begin
            errors++; $display("FAIL reset_blocks_write a=%h b=%h expected 0 0", bus.a, bus.b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_branch();
        test_jump();
        test_shift_lui_sw();
        test_r0();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
